// File: rtl/iic_burst_writer.sv
// I2C burst writer: START, slave address, control byte, len data bytes from a
// ready/valid stream, STOP. Bus timing is built from CLK_DIV-cycle quarter periods.
module iic_burst_writer #(
    parameter logic [7:0] SLAVE_ADDR = 8'h78,
    parameter int         CLK_DIV    = 125,
    parameter int         LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dc,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             busy,
    output logic             done,
    output logic             nack,
    output logic             scl,
    output logic             sda_oe,
    input  logic             sda_in
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_FETCH = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_ADDR = 2'd0,
        PH_CTRL = 2'd1,
        PH_DATA = 2'd2
    } phase_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_t             state_r, state_s;
    phase_t             phase_r, phase_s;
    logic [1:0]         quarter_r, quarter_s;
    logic [15:0]        div_r, div_s;
    logic [2:0]         bit_cnt_r, bit_cnt_s;
    logic [7:0]         shift_r, shift_s;
    logic [7:0]         ctrl_r, ctrl_s;
    logic [LEN_W-1:0]   rem_r, rem_s;
    logic               ack_bad_r, ack_bad_s;
    logic               abort_r, abort_s;
    logic               scl_r, scl_s;
    logic               sda_oe_r, sda_oe_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               nack_r, nack_s;
    logic               din_ready_r, din_ready_s;
    logic               tick_s;
    logic               qend_s;

    function automatic logic scl_level(input state_t st, input logic [1:0] q);
        case (st)
            ST_IDLE:         scl_level = 1'b1;
            ST_START:        scl_level = (q != 2'd3);
            ST_BIT, ST_ACK:  scl_level = (q == 2'd1) || (q == 2'd2);
            ST_FETCH:        scl_level = 1'b0;
            ST_STOP:         scl_level = (q != 2'd0);
            default:         scl_level = 1'b1;
        endcase
    endfunction

    // SDA drive level; FETCH keeps whatever the line had so the bus is frozen
    function automatic logic sda_level(input state_t st, input logic [1:0] q,
                                       input logic msb, input logic hold);
        case (st)
            ST_IDLE:  sda_level = 1'b0;
            ST_START: sda_level = (q != 2'd0);
            ST_BIT:   sda_level = ~msb;
            ST_ACK:   sda_level = 1'b0;
            ST_FETCH: sda_level = hold;
            ST_STOP:  sda_level = (q == 2'd0) || (q == 2'd1);
            default:  sda_level = 1'b0;
        endcase
    endfunction

    // Next-state, datapath and next-output computation
    always_comb begin
        state_s   = state_r;
        phase_s   = phase_r;
        div_s     = div_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        ctrl_s    = ctrl_r;
        rem_s     = rem_r;
        ack_bad_s = ack_bad_r;
        abort_s   = abort_r;
        done_s    = 1'b0;
        nack_s    = 1'b0;
        tick_s    = (div_r == DIV_LAST);
        qend_s    = tick_s && (quarter_r == 2'd3);

        if ((state_r == ST_IDLE) || (state_r == ST_FETCH)) begin
            div_s = 16'd0;
        end else if (tick_s) begin
            div_s = 16'd0;
        end else begin
            div_s = div_r + 16'd1;
        end

        if (tick_s) begin
            quarter_s = quarter_r + 2'd1;
        end else begin
            quarter_s = quarter_r;
        end

        case (state_r)
            ST_IDLE: begin
                quarter_s = 2'd0;
                if (start) begin
                    state_s   = ST_START;
                    phase_s   = PH_ADDR;
                    shift_s   = SLAVE_ADDR;
                    ctrl_s    = dc ? 8'h40 : 8'h00;
                    rem_s     = len;
                    bit_cnt_s = 3'd0;
                    ack_bad_s = 1'b0;
                    abort_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (qend_s) begin
                    state_s   = ST_BIT;
                    bit_cnt_s = 3'd0;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_BIT: begin
                if (qend_s) begin
                    shift_s = {shift_r[6:0], 1'b0};
                    if (bit_cnt_r == 3'd7) begin
                        state_s   = ST_ACK;
                        bit_cnt_s = 3'd0;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_s = ST_BIT;
                end
            end
            ST_ACK: begin
                // slave's answer is latched at the Q1->Q2 boundary, acted on after Q3
                if (tick_s && (quarter_r == 2'd1)) begin
                    ack_bad_s = sda_in;
                end else begin
                    ack_bad_s = ack_bad_r;
                end
                if (qend_s) begin
                    if (ack_bad_r) begin
                        abort_s = 1'b1;
                        state_s = ST_STOP;
                    end else begin
                        case (phase_r)
                            PH_ADDR: begin
                                shift_s   = ctrl_r;
                                phase_s   = PH_CTRL;
                                bit_cnt_s = 3'd0;
                                state_s   = ST_BIT;
                            end
                            PH_CTRL, PH_DATA: begin
                                phase_s = PH_DATA;
                                if (rem_r == {LEN_W{1'b0}}) begin
                                    state_s = ST_STOP;
                                end else begin
                                    state_s = ST_FETCH;
                                end
                            end
                            default: state_s = ST_STOP;
                        endcase
                    end
                end else begin
                    state_s = ST_ACK;
                end
            end
            ST_FETCH: begin
                quarter_s = 2'd0;
                if (din_valid) begin
                    shift_s   = din;
                    bit_cnt_s = 3'd0;
                    state_s   = ST_BIT;
                    if (rem_r != {LEN_W{1'b0}}) begin
                        rem_s = rem_r - LEN_W'(1);
                    end else begin
                        rem_s = rem_r;
                    end
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_STOP: begin
                if (qend_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                    nack_s  = abort_r;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        scl_s       = scl_level(state_s, quarter_s);
        sda_oe_s    = sda_level(state_s, quarter_s, shift_s[7], sda_oe_r);
        busy_s      = (state_s != ST_IDLE);
        din_ready_s = (state_s == ST_FETCH);
    end

    // State and registered outputs; reset forces an idle, released bus at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            phase_r     <= PH_ADDR;
            quarter_r   <= 2'd0;
            div_r       <= 16'd0;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            ctrl_r      <= 8'h00;
            rem_r       <= {LEN_W{1'b0}};
            ack_bad_r   <= 1'b0;
            abort_r     <= 1'b0;
            scl_r       <= 1'b1;
            sda_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            nack_r      <= 1'b0;
            din_ready_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_r     <= phase_s;
            quarter_r   <= quarter_s;
            div_r       <= div_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            ctrl_r      <= ctrl_s;
            rem_r       <= rem_s;
            ack_bad_r   <= ack_bad_s;
            abort_r     <= abort_s;
            scl_r       <= scl_s;
            sda_oe_r    <= sda_oe_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            nack_r      <= nack_s;
            din_ready_r <= din_ready_s;
        end
    end

    assign scl       = scl_r;
    assign sda_oe    = sda_oe_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign nack      = nack_r;
    assign din_ready = din_ready_r;

endmodule

// File: tb/tb_iic_burst_writer.sv
// Directed bench for iic_burst_writer: table of transactions with hand-computed
// cycle counts, an I2C byte decoder on the bus, and a mid-transaction reset sequence.
module tb_iic_burst_writer;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dc;
    logic [7:0] len;
    logic [7:0] din;
    logic       din_valid;
    logic       sda_in;
    logic       din_ready;
    logic       busy;
    logic       done;
    logic       nack;
    logic       scl;
    logic       sda_oe;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iic_burst_writer #(
        .SLAVE_ADDR(8'h78),
        .CLK_DIV   (CLK_DIV),
        .LEN_W     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dc       (dc),
        .len      (len),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .busy     (busy),
        .done     (done),
        .nack     (nack),
        .scl      (scl),
        .sda_oe   (sda_oe),
        .sda_in   (sda_in)
    );

    // bus decoder: bits on SCL rise, START/STOP on SDA edges while SCL high
    logic [7:0] mon_q[$];
    logic [7:0] mon_sr = 8'h00;
    int         mon_bits = 0;
    logic       prev_scl = 1'b1;
    logic       prev_line = 1'b1;

    always @(negedge clk) begin
        if (scl && !prev_scl) begin
            if (mon_bits == 8) begin
                mon_q.push_back(mon_sr);
                mon_bits <= 0;
            end else begin
                mon_sr   <= {mon_sr[6:0], ~sda_oe};
                mon_bits <= mon_bits + 1;
            end
        end else if (scl && prev_scl && (prev_line != ~sda_oe)) begin
            mon_bits <= 0;
        end
        prev_scl  <= scl;
        prev_line <= ~sda_oe;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        dc;
        int          len;
        logic [31:0] data;        // first byte in [31:24]
        int          stall_at;    // byte index whose fetch is stalled, -1 none
        int          stall_len;
        logic        nack_mode;   // slave answers NACK on the address
        int          extra_start; // cycle of a start pulse while busy, 0 none
        int          exp_cycles;
        logic        exp_nack;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input string tag, input vec_t v);
        int          idx, stall_cnt, cyc, dones, rdy_cycles, base, done_cyc, extra_dones, exp_n;
        logic        nack_seen, got_busy, stall_bad, stall_sda, valid_now;
        logic [31:0] tmp;
        logic [7:0]  exp_b[6];

        idx = 0; stall_cnt = 0; cyc = 0; dones = 0; rdy_cycles = 0; done_cyc = 0;
        nack_seen = 1'b0; got_busy = 1'b0; stall_bad = 1'b0; stall_sda = 1'b0;
        base = mon_q.size();
        exp_b[0] = 8'h78;
        exp_b[1] = v.dc ? 8'h40 : 8'h00;
        for (int i = 0; i < 4; i++) begin
            tmp = v.data << (8 * i);
            exp_b[2 + i] = tmp[31:24];
        end
        exp_n = v.exp_nack ? 1 : 2 + v.len;

        sda_in    = v.nack_mode;
        dc        = v.dc;
        len       = 8'(v.len);
        tmp       = v.data;
        din       = tmp[31:24];
        din_valid = (v.stall_at != 0);
        start     = 1'b1;
        while (dones == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == v.extra_start);
            if (cyc == 1) got_busy = busy;
            if (done) begin
                dones++;
                done_cyc  = cyc;
                nack_seen = nack;
            end
            valid_now = !((idx == v.stall_at) && (stall_cnt < v.stall_len));
            tmp       = v.data << (8 * (idx & 3));
            din       = tmp[31:24];
            din_valid = valid_now;
            if (din_ready) begin
                rdy_cycles++;
                if (valid_now) begin
                    idx++;
                end else begin
                    if (stall_cnt == 0) stall_sda = sda_oe;
                    if (scl !== 1'b0 || sda_oe !== stall_sda) stall_bad = 1'b1;
                    stall_cnt++;
                end
            end
        end
        start = 1'b0;
        din_valid = 1'b0;
        chk({tag, " done_seen"}, 32'(dones), 32'd1);
        chk({tag, " cycles"}, 32'(done_cyc), 32'(v.exp_cycles));
        chk({tag, " nack"}, {31'd0, nack_seen}, {31'd0, v.exp_nack});
        chk({tag, " busy_after_start"}, {31'd0, got_busy}, 32'd1);

        extra_dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) extra_dones++;
        end
        chk({tag, " no_extra_done"}, 32'(extra_dones), 32'd0);
        chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " idle_scl"}, {31'd0, scl}, 32'd1);

        chk({tag, " byte_count"}, 32'(mon_q.size() - base), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            if (base + i < mon_q.size()) begin
                chk($sformatf("%s byte%0d", tag, i), {24'd0, mon_q[base + i]}, {24'd0, exp_b[i]});
            end
        end
        chk({tag, " accepted"}, 32'(idx), v.exp_nack ? 32'd0 : 32'(v.len));
        chk({tag, " ready_cycles"}, 32'(rdy_cycles),
            v.exp_nack ? 32'd0 : 32'(v.len + v.stall_len));
        if (v.stall_len > 0) chk({tag, " stall_bus_frozen"}, {31'd0, stall_bad}, 32'd0);
        sda_in = 1'b0;
    endtask

    initial begin
        int   dn;
        vec_t rv;

        vecs[0] = '{1'b1, 1, 32'hA500_0000, -1,  0, 1'b0,   0, 466, 1'b0};
        vecs[1] = '{1'b0, 0, 32'h0000_0000, -1,  0, 1'b0,   0, 321, 1'b0};
        vecs[2] = '{1'b1, 3, 32'h1122_3300, -1,  0, 1'b0, 100, 756, 1'b0};
        vecs[3] = '{1'b1, 3, 32'hC35A_FF00,  1, 50, 1'b0,   0, 806, 1'b0};
        vecs[4] = '{1'b1, 2, 32'h1234_0000, -1,  0, 1'b1,   0, 177, 1'b1};
        vecs[5] = '{1'b0, 2, 32'h0080_0000, -1,  0, 1'b0,   0, 611, 1'b0};

        rst = 1'b1; start = 1'b0; dc = 1'b0; len = 8'd0; din = 8'h00;
        din_valid = 1'b0; sda_in = 1'b0;
        @(negedge clk);
        chk("reset scl", {31'd0, scl}, 32'd1);
        chk("reset sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset nack", {31'd0, nack}, 32'd0);
        chk("reset din_ready", {31'd0, din_ready}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // reset in the middle of the control byte (bit 2, Q0: SCL low, SDA driven low)
        dc = 1'b1; len = 8'd1; din = 8'hA5; din_valid = 1'b0; sda_in = 1'b0;
        start = 1'b1;
        dn = 0;
        for (int c = 1; c <= 194; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dn++;
        end
        chk("pre_reset scl", {31'd0, scl}, 32'd0);
        chk("pre_reset sda_oe", {31'd0, sda_oe}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset scl", {31'd0, scl}, 32'd1);
        chk("async_reset sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("async_reset busy", {31'd0, busy}, 32'd0);
        chk("async_reset din_ready", {31'd0, din_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("reset_abort no_done", 32'(dn), 32'd0);
        chk("reset_abort idle", {31'd0, busy}, 32'd0);

        rv = vecs[0];
        run_vec("after_reset", rv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iic_burst_writer.md
IIC_BURST_WRITER -- requirements
Module: iic_burst_writer

Interface
REQ-001 Parameter SLAVE_ADDR, default 8'h78, 8-bit write address byte (R/W bit = 0) sent first in every transaction.
REQ-002 Parameter CLK_DIV, default 125, number of clk cycles per quarter SCL period; legal range 2..65535.
REQ-003 Parameter LEN_W, default 8, width of the data byte count.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  single-cycle transaction request; sampled only in IDLE.
REQ-007 dc  input  1  sampled with start; 1 -> control byte 8'h40, 0 -> control byte 8'h00.
REQ-008 len  input  LEN_W  number of data bytes after the control byte; sampled with start; 0 is legal.
REQ-009 din  input  8  data byte; accepted when din_valid and din_ready are both 1.
REQ-010 din_valid  input  1  source has a byte on din.
REQ-011 din_ready  output  1  block is requesting the next data byte.
REQ-012 busy  output  1  high from the cycle after start is accepted until the cycle done pulses.
REQ-013 done  output  1  one-cycle pulse at transaction end, whether success or abort.
REQ-014 nack  output  1  one-cycle pulse, coincident with done, when the transaction was aborted on NACK.
REQ-015 scl  output  1  I2C clock, push-pull; 1 = released/high.
REQ-016 sda_oe  output  1  1 = drive SDA low, 0 = release SDA (open-drain, external pull-up).
REQ-017 sda_in  input  1  sampled SDA line level.

Function
REQ-018 A quarter tick SHALL fire every CLK_DIV cycles while busy; the divider SHALL be cleared in IDLE and on every exit from FETCH.
REQ-019 States: IDLE, START, BIT, ACK, FETCH, STOP; each of START, BIT, ACK and STOP lasts exactly four quarters (Q0..Q3).
REQ-020 IDLE: scl=1, sda_oe=0; start=1 captures dc and len, loads SLAVE_ADDR into the shift register, and moves to START; start while busy is ignored.
REQ-021 START: Q0 scl=1/SDA released; Q1 SDA low; Q2 hold; Q3 scl=0.
REQ-022 BIT: SDA updated to the current MSB at the start of Q0 with scl=0; scl=1 during Q1-Q2; scl=0 in Q3; shift left after Q3; eight BITs per byte, MSB first.
REQ-023 ACK: SDA released for all four quarters; scl high during Q1-Q2; sda_in sampled at the Q1->Q2 boundary; sampled 1 = NACK.
REQ-024 Byte order: address byte, then control byte, then len data bytes, then STOP.
REQ-025 After the address ACK, the control byte SHALL be loaded directly; after the control ACK and after each data ACK with bytes remaining, the block SHALL enter FETCH.
REQ-026 FETCH: scl=0, SDA held; din_ready=1 only in this state; the block SHALL leave on the first cycle with din_valid=1, loading din into the shift register and entering BIT. An indefinite stall is legal and SHALL hold the bus in this state.
REQ-027 len=0 SHALL send the address and control byte only, then STOP.
REQ-028 NACK on any byte SHALL skip all remaining bytes, with no further din_ready, and go to STOP; nack pulses with done.
REQ-029 STOP: Q0 scl=0/SDA low; Q1 scl=1; Q2 SDA released; Q3 hold; at the end of Q3, done pulses and the state returns to IDLE.
REQ-030 The success transaction length from the start cycle to the done cycle SHALL be 1 + CLK_DIV*(8 + 36*(2+len)) + F clk cycles, where F is the total number of FETCH cycles (at least one per data byte).
REQ-031 The remaining-byte counter SHALL be LEN_W bits, decrement once per accepted byte, and never wrap.

Reset
REQ-032 While rst=1, all outputs SHALL be immediately: scl=1, sda_oe=0, busy=0, done=0, nack=0, din_ready=0; state IDLE; divider and counters zero.
REQ-033 Reset mid-transaction SHALL abort without a STOP and without done; the next start after rst falls begins a fresh transaction.

Verification
REQ-034 CLK_DIV=4, dc=1, len=1, din=8'hA5 held valid, slave ACKs all -> decoded bytes 78,40,A5; done only, nack=0; done at cycle 1+4*116+1=466 after start.
REQ-035 dc=0, len=0 -> bytes 78,00 then STOP; din_ready never asserted; done after 1+4*80 cycles.
REQ-036 len=3, din_valid withheld 50 cycles at the second FETCH -> scl stays 0 and SDA is unchanged for the stall; bytes are sent in order; the cycle count grows by exactly 50.
REQ-037 sda_in held high at the address ACK -> STOP follows immediately; done and nack pulse together; no din_ready.
REQ-038 rst asserted mid-BIT of the control byte -> scl=1 and sda_oe=0 in the same cycle with no clk edge; no done; a new start after release produces a correct full transaction.
REQ-039 start pulsed while busy -> ignored; exactly one done per accepted start.
